// File: rtl/imm_pkg.sv
// Shared encodings and types for the immediate-operand sequencer.
// Holds mode/state codes, operand width and the loader result bundle.
package imm_pkg;

  localparam int OP_W  = 32;
  localparam int CNT_W = 5;

  localparam logic [1:0] MODE_ROT  = 2'b00;
  localparam logic [1:0] MODE_SEXT = 2'b01;
  localparam logic [1:0] MODE_ZEXT = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ROTATE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam int ROT_STEP_1 = 1;
  localparam int ROT_STEP_2 = 2;

  // Initial working value and rotate count produced by the loader.
  typedef struct packed {
    logic [OP_W-1:0]  w;
    logic [CNT_W-1:0] cnt;
    logic             rot_en;
    logic             err;
  } load_t;

endpackage

// File: rtl/imm_operand_seq_if.sv
// Request/result bundle between an operand requester and imm_operand_seq.
// REQ is a valid taken only when the sequencer is IDLE or DONE with ACK; DONE is a
// valid held with Q/SHIFT_C/ERR stable until ACK, and the result retires on the edge with ACK=1.
interface imm_operand_seq_if;
  logic        REQ;
  logic [1:0]  MODE;
  logic [11:0] IMM;
  logic        CIN;
  logic        ACK;
  logic        BUSY;
  logic        DONE;
  logic [31:0] Q;
  logic        SHIFT_C;
  logic        ERR;

  modport master (output REQ, MODE, IMM, CIN, ACK,
                  input  BUSY, DONE, Q, SHIFT_C, ERR);
  modport slave  (input  REQ, MODE, IMM, CIN, ACK,
                  output BUSY, DONE, Q, SHIFT_C, ERR);
endinterface

// File: rtl/imm_extend.sv
// Combinational 12-to-32 operand loader: picks the initial working value
// and rotate count from the mode and immediate field.
module imm_extend import imm_pkg::*; #(
  parameter int ROT_STEP = 2
) (
  input  logic [1:0]  mode,
  input  logic [11:0] imm,
  output load_t       ld
);

  always_comb begin
    ld = '0;
    case (mode)
      MODE_SEXT: ld.w = {{20{imm[11]}}, imm};
      MODE_ZEXT: ld.w = {20'd0, imm};
      MODE_ROT: begin
        ld.w      = {24'd0, imm[7:0]};
        ld.rot_en = (imm[11:8] != 4'd0);
        // rot counts 2-bit positions; a 1-bit rotator needs twice the steps.
        ld.cnt    = (ROT_STEP == ROT_STEP_1) ? {imm[11:8], 1'b0} : {1'b0, imm[11:8]};
      end
      default: ld.err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_operand_seq.sv
// Immediate-operand sequencer: loads an extended or rotated immediate, rotates
// it ROT_STEP bits per cycle where needed and holds the result until ACK.
module imm_operand_seq import imm_pkg::*; #(
  parameter int ROT_STEP = 2
) (
  input  logic              CLK,
  input  logic              CLR,
  imm_operand_seq_if.slave  bus,
  output logic [1:0]        state
);

  logic [1:0]       state_q, state_d;
  logic [OP_W-1:0]  w_q, w_d, w_rot, q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             cin_q, cin_d, rot_en_q, rot_en_d;
  logic             c_q, c_d, err_q, err_d;
  logic             accept;
  load_t            ld;

  imm_extend #(.ROT_STEP(ROT_STEP)) u_extend (
    .mode (bus.MODE),
    .imm  (bus.IMM),
    .ld   (ld)
  );

  assign w_rot  = {w_q[ROT_STEP-1:0], w_q[OP_W-1:ROT_STEP]};
  assign accept = bus.REQ && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.ACK));

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    cin_d    = cin_q;
    rot_en_d = rot_en_q;
    q_d      = q_q;
    c_d      = c_q;
    err_d    = err_q;

    case (state_q)
      ST_ROTATE: begin
        if (rot_en_q) begin
          w_d   = w_rot;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_d = ST_DONE;
            q_d     = w_rot;
            c_d     = w_rot[OP_W-1];
            err_d   = 1'b0;
          end
        end else begin
          // One-cycle bubble so DONE visibly drops between back-to-back results.
          state_d = ST_DONE;
          q_d     = w_q;
          c_d     = cin_q & (mode_q != MODE_RSVD);
          err_d   = (mode_q == MODE_RSVD);
        end
      end
      ST_DONE: if (bus.ACK && !bus.REQ) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      w_d      = ld.w;
      cnt_d    = ld.cnt;
      mode_d   = bus.MODE;
      cin_d    = bus.CIN;
      rot_en_d = ld.rot_en;
      if (ld.rot_en || (state_q == ST_DONE)) begin
        state_d = ST_ROTATE;
      end else begin
        state_d = ST_DONE;
        q_d     = ld.w;
        c_d     = bus.CIN & ~ld.err;
        err_d   = ld.err;
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q  <= ST_IDLE;
      w_q      <= '0;
      cnt_q    <= '0;
      mode_q   <= MODE_ROT;
      cin_q    <= 1'b0;
      rot_en_q <= 1'b0;
      q_q      <= '0;
      c_q      <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      cin_q    <= cin_d;
      rot_en_q <= rot_en_d;
      q_q      <= q_d;
      c_q      <= c_d;
      err_q    <= err_d;
    end
  end

  assign bus.BUSY    = (state_q == ST_ROTATE) || (state_q == ST_DONE);
  assign bus.DONE    = (state_q == ST_DONE);
  assign bus.Q       = q_q;
  assign bus.SHIFT_C = c_q;
  assign bus.ERR     = err_q;
  assign state       = state_q;

endmodule
